// File: rtl/keyboard_pkg.sv
// Shared definitions for the keyboard front end.
//   kbd_mode_e : KBD word presentation (held-key level or buffered FIFO head)
//   HACK_KEY_W : width of a translated Hack key code
//   KEY_*      : Hack codes for the non-printing keys
//   max_u      : elaboration-time helper used to size counters
package keyboard_pkg;

  typedef enum logic {
    KBD_MODE_LEVEL,
    KBD_MODE_BUFFERED
  } kbd_mode_e;

  localparam int unsigned HACK_KEY_W = 8;

  localparam logic [HACK_KEY_W-1:0] KEY_NEWLINE   = 8'd128;
  localparam logic [HACK_KEY_W-1:0] KEY_BACKSPACE = 8'd129;
  localparam logic [HACK_KEY_W-1:0] KEY_LEFT      = 8'd130;
  localparam logic [HACK_KEY_W-1:0] KEY_UP        = 8'd131;
  localparam logic [HACK_KEY_W-1:0] KEY_RIGHT     = 8'd132;
  localparam logic [HACK_KEY_W-1:0] KEY_DOWN      = 8'd133;
  localparam logic [HACK_KEY_W-1:0] KEY_HOME      = 8'd134;
  localparam logic [HACK_KEY_W-1:0] KEY_END       = 8'd135;
  localparam logic [HACK_KEY_W-1:0] KEY_PAGE_UP   = 8'd136;
  localparam logic [HACK_KEY_W-1:0] KEY_PAGE_DOWN = 8'd137;
  localparam logic [HACK_KEY_W-1:0] KEY_INSERT    = 8'd138;
  localparam logic [HACK_KEY_W-1:0] KEY_DELETE    = 8'd139;
  localparam logic [HACK_KEY_W-1:0] KEY_ESC       = 8'd140;
  localparam logic [HACK_KEY_W-1:0] KEY_F1        = 8'd141;
  localparam logic [HACK_KEY_W-1:0] KEY_F2        = 8'd142;
  localparam logic [HACK_KEY_W-1:0] KEY_F3        = 8'd143;
  localparam logic [HACK_KEY_W-1:0] KEY_F4        = 8'd144;
  localparam logic [HACK_KEY_W-1:0] KEY_F5        = 8'd145;
  localparam logic [HACK_KEY_W-1:0] KEY_F6        = 8'd146;
  localparam logic [HACK_KEY_W-1:0] KEY_F7        = 8'd147;
  localparam logic [HACK_KEY_W-1:0] KEY_F8        = 8'd148;
  localparam logic [HACK_KEY_W-1:0] KEY_F9        = 8'd149;
  localparam logic [HACK_KEY_W-1:0] KEY_F10       = 8'd150;
  localparam logic [HACK_KEY_W-1:0] KEY_F11       = 8'd151;
  localparam logic [HACK_KEY_W-1:0] KEY_F12       = 8'd152;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: write strobe and data (ignored when full unless popping)
//   i_pop        : read strobe (ignored when empty)
//   o_head       : current head entry
//   o_count      : occupancy; o_full / o_empty status
module kbd_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A pop frees the slot the simultaneous push needs, so push+pop when full is legal.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/keyboard_fifo.sv
// KBD word source: held-key tracking, auto-repeat, typematic filter, keystroke FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   hack, hack_valid  : translated key code and one-cycle strobe (code 0 ignored)
//   pressed           : 1 = make, 0 = break
//   rd_en             : pop the FIFO head
//   clr_ovf           : clear the sticky overflow flag
//   value             : KBD word (held key in LEVEL mode, FIFO head in BUFFERED)
//   fifo_count        : FIFO occupancy
//   overflow          : sticky, set when a push is dropped
module keyboard_fifo
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter kbd_mode_e   MODE          = KBD_MODE_BUFFERED,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [HACK_KEY_W-1:0]           hack,
  input  logic                            hack_valid,
  input  logic                            pressed,
  input  logic                            rd_en,
  input  logic                            clr_ovf,
  output logic [15:0]                     value,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int unsigned TMR_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  // Loaded with N-1 so the push lands N cycles after the arming push.
  localparam logic [TMR_W-1:0] TMR_DLY = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] TMR_PER = TMR_W'(REPEAT_PERIOD - 1);

  logic [HACK_KEY_W-1:0] r_held;
  logic                  r_held_vld;
  logic [TMR_W-1:0]      r_tmr;
  logic                  r_tmr_run;
  logic                  r_ovf;

  logic                  w_evt;
  logic                  w_same;
  logic                  w_new_press;
  logic                  w_typ_push;
  logic                  w_release;
  logic                  w_expire;
  logic                  w_rpt_push;
  logic                  w_push;
  logic [HACK_KEY_W-1:0] w_push_data;
  logic [HACK_KEY_W-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;

  assign w_evt       = hack_valid && (hack != '0);
  assign w_same      = r_held_vld && (hack == r_held);
  assign w_new_press = w_evt && pressed && !w_same;
  assign w_typ_push  = w_evt && pressed && w_same && !REPEAT_EN;
  assign w_release   = w_evt && !pressed && w_same;
  assign w_expire    = REPEAT_EN && r_tmr_run && r_held_vld && (r_tmr == '0);
  // A new press or the release of the held key pre-empts a coincident repeat.
  assign w_rpt_push  = w_expire && !w_new_press && !w_release;
  assign w_push      = w_new_press || w_typ_push || w_rpt_push;
  assign w_push_data = (w_new_press || w_typ_push) ? hack : r_held;
  assign w_drop      = w_push && w_full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held     <= '0;
      r_held_vld <= 1'b0;
    end else if (w_new_press) begin
      r_held     <= hack;
      r_held_vld <= 1'b1;
    end else if (w_release) begin
      r_held_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr     <= '0;
      r_tmr_run <= 1'b0;
    end else if (REPEAT_EN && w_new_press) begin
      r_tmr     <= TMR_DLY;
      r_tmr_run <= 1'b1;
    end else if (w_release) begin
      r_tmr_run <= 1'b0;
    end else if (w_expire) begin
      r_tmr     <= TMR_PER;
    end else if (r_tmr_run) begin
      r_tmr     <= r_tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  kbd_sync_fifo #(
    .WIDTH (HACK_KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rd_en),
    .o_head  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    value = '0;
    if (MODE == KBD_MODE_LEVEL) begin
      if (r_held_vld) value[HACK_KEY_W-1:0] = r_held;
    end else begin
      if (!w_empty) value[HACK_KEY_W-1:0] = w_head;
    end
  end

  assign overflow = r_ovf;

endmodule
